// File: rtl/game_sequencer_if.sv
// Brick-hit probe handshake between the ball engine (master) and the game sequencer (slave).
interface game_sequencer_if;
    logic       hit_req;
    logic [3:0] hit_x;
    logic [3:0] hit_y;
    logic       hit_ack;
    logic       hit_brick;

    modport master (output hit_req, hit_x, hit_y, input  hit_ack, hit_brick);
    modport slave  (input  hit_req, hit_x, hit_y, output hit_ack, hit_brick);
endinterface

// File: rtl/game_sequencer.sv
// Brick-breaker game controller: phase FSM, ball-step tick, brick map, score and lives,
// plus one-cycle brick-hit arbitration for the ball engine.
module game_sequencer #(
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned BRICK_ROWS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      launch_btn_i,
    input  logic                      fall_down_i,
    game_sequencer_if.slave           hit,
    output logic                      step_o,
    output logic                      ball_rst_o,
    output logic                      launch_o,
    output logic [10*BRICK_ROWS-1:0]  brick_map_o,
    output logic [7:0]                score_o,
    output logic [2:0]                lives_o,
    output logic [2:0]                state_o,
    output logic                      game_win_o,
    output logic                      game_over_o
);
    localparam int unsigned NB         = 10 * BRICK_ROWS;
    localparam int unsigned BRICK_BASE = 10 - BRICK_ROWS;
    localparam int unsigned IW         = $clog2(NB);
    localparam int unsigned CW         = $clog2(TICK_DIV);
    localparam logic [3:0]  BASE_Y     = 4'(BRICK_BASE);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [NB-1:0]   map_q, map_d;
    logic [7:0]      score_q, score_d;
    logic [2:0]      lives_q, lives_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_prev_q, launch_prev_q, fall_prev_q;
    logic            step_q, step_d, ball_rst_q, ball_rst_d, launch_q, launch_d;
    logic            ack_q, ack_d, brick_q, brick_d, win_q, over_q;
    logic            start_rise_s, launch_rise_s, fall_rise_s, in_range_s;
    logic [IW-1:0]   idx_s;

    assign start_rise_s  = start_i & ~start_prev_q;
    assign launch_rise_s = launch_btn_i & ~launch_prev_q;
    assign fall_rise_s   = fall_down_i & ~fall_prev_q;
    assign in_range_s    = (state_q == S_PLAY) && (hit.hit_x <= 4'd9) &&
                           (hit.hit_y >= BASE_Y) && (hit.hit_y <= 4'd9);
    assign idx_s         = IW'((32'(hit.hit_y) - BRICK_BASE) * 32'd10 + 32'(hit.hit_x));

    // Next-state logic: hit arbitration, phase transitions and the step tick.
    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        score_d    = score_q;
        lives_d    = lives_q;
        cnt_d      = '0;
        step_d     = 1'b0;
        ball_rst_d = 1'b0;
        launch_d   = 1'b0;
        ack_d      = hit.hit_req;
        brick_d    = 1'b0;

        if (hit.hit_req && in_range_s && map_q[idx_s]) begin
            brick_d      = 1'b1;
            map_d[idx_s] = 1'b0;
            score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        end else begin
            brick_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                map_d   = {NB{1'b1}};
                score_d = 8'd0;
                lives_d = LIVES_INIT;
                if (start_rise_s) begin
                    state_d    = S_SERVE;
                    ball_rst_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SERVE: begin
                if (launch_rise_s) begin
                    state_d  = S_PLAY;
                    launch_d = 1'b1;
                end else begin
                    state_d = S_SERVE;
                end
            end
            S_PLAY: begin
                // Emptiness is judged on the map before this cycle's hit lands.
                if (map_q == '0) begin
                    state_d = S_WIN;
                end else if (fall_rise_s) begin
                    state_d = S_MISS;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_MISS: begin
                if (map_q == '0) begin
                    state_d = S_WIN;
                end else if (lives_q == 3'd1) begin
                    lives_d = 3'd0;
                    state_d = S_OVER;
                end else begin
                    lives_d    = lives_q - 3'd1;
                    state_d    = S_SERVE;
                    ball_rst_d = 1'b1;
                end
            end
            S_WIN, S_OVER: begin
                if (start_rise_s) begin
                    map_d      = {NB{1'b1}};
                    score_d    = 8'd0;
                    lives_d    = LIVES_INIT;
                    state_d    = S_SERVE;
                    ball_rst_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The tick only advances while play continues across this edge.
        if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
            if (cnt_q == CW'(TICK_DIV - 1)) begin
                cnt_d  = '0;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            map_q         <= {NB{1'b1}};
            score_q       <= 8'd0;
            lives_q       <= LIVES_INIT;
            cnt_q         <= '0;
            start_prev_q  <= 1'b0;
            launch_prev_q <= 1'b0;
            fall_prev_q   <= 1'b0;
            step_q        <= 1'b0;
            ball_rst_q    <= 1'b0;
            launch_q      <= 1'b0;
            ack_q         <= 1'b0;
            brick_q       <= 1'b0;
            win_q         <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            map_q         <= map_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            cnt_q         <= cnt_d;
            start_prev_q  <= start_i;
            launch_prev_q <= launch_btn_i;
            fall_prev_q   <= fall_down_i;
            step_q        <= step_d;
            ball_rst_q    <= ball_rst_d;
            launch_q      <= launch_d;
            ack_q         <= ack_d;
            brick_q       <= brick_d;
            win_q         <= (state_d == S_WIN);
            over_q        <= (state_d == S_OVER);
        end
    end

    assign step_o        = step_q;
    assign ball_rst_o    = ball_rst_q;
    assign launch_o      = launch_q;
    assign brick_map_o   = map_q;
    assign score_o       = score_q;
    assign lives_o       = lives_q;
    assign state_o       = state_q;
    assign game_win_o    = win_q;
    assign game_over_o   = over_q;
    assign hit.hit_ack   = ack_q;
    assign hit.hit_brick = brick_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, multi-cycle corner sequences, and
// randomized play checked against a procedural game model.
module tb_game_sequencer;
    localparam int TICK    = 4;
    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_MISS  = 3;
    localparam int P_WIN   = 4;
    localparam int P_OVER  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s = 1'b0, launch_s = 1'b0, fall_s = 1'b0;
    logic        step_s, brst_s, lnch_s, win_s, over_s;
    logic [19:0] map_s;
    logic [7:0]  score_s;
    logic [2:0]  lives_s, state_s;

    game_sequencer_if hif();

    game_sequencer #(.TICK_DIV(TICK), .LIVES(3), .BRICK_ROWS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_s), .launch_btn_i(launch_s),
        .fall_down_i(fall_s), .hit(hif), .step_o(step_s), .ball_rst_o(brst_s),
        .launch_o(lnch_s), .brick_map_o(map_s), .score_o(score_s), .lives_o(lives_s),
        .state_o(state_s), .game_win_o(win_s), .game_over_o(over_s)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference game model
    int        m_phase, m_score, m_lives, m_tick;
    bit [19:0] m_map;
    bit        m_ps, m_pl, m_pf, m_step, m_br, m_la, m_ack, m_brk;

    function automatic logic [40:0] pack(int st, logic [19:0] mp, int sc, int lv,
                                         bit stp, bit br, bit la, bit ack, bit brk);
        return {3'(st), mp, 8'(sc), 3'(lv), stp, br, la, ack, brk, st == P_WIN, st == P_OVER};
    endfunction

    function automatic logic [40:0] got_vec();
        return {state_s, map_s, score_s, lives_s, step_s, brst_s, lnch_s,
                hif.hit_ack, hif.hit_brick, win_s, over_s};
    endfunction

    task automatic check_vec(string name, logic [40:0] exp);
        logic [40:0] g;
        g = got_vec();
        total++;
        if (g !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, g, exp);
        end
    endtask

    task automatic check_val(string name, int g, int e);
        total++;
        if (g != e) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, g, e);
        end
    endtask

    task automatic check_model(string name);
        check_vec(name, pack(m_phase, m_map, m_score, m_lives, m_step, m_br, m_la, m_ack, m_brk));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_map = '1; m_score = 0; m_lives = 3; m_tick = 0;
        m_ps = 0; m_pl = 0; m_pf = 0;
        m_step = 0; m_br = 0; m_la = 0; m_ack = 0; m_brk = 0;
    endtask

    task automatic model_edge(bit s, bit l, bit f, bit req, int x, int y);
        bit sr, lr, fr, was_play, empty;
        int nxt, idx;
        sr = s && !m_ps; lr = l && !m_pl; fr = f && !m_pf;
        was_play = (m_phase == P_PLAY);
        empty = (m_map == 20'd0);
        nxt = m_phase;
        m_ack = req; m_brk = 0; m_br = 0; m_la = 0; m_step = 0;
        if (req && was_play && x <= 9 && y >= 8 && y <= 9) begin
            idx = (y - 8) * 10 + x;
            if (m_map[idx]) begin
                m_brk = 1;
                m_map[idx] = 0;
                if (m_score < 255) m_score++;
            end
        end
        case (m_phase)
            P_IDLE: begin
                m_map = '1; m_score = 0; m_lives = 3;
                if (sr) begin nxt = P_SERVE; m_br = 1; end
            end
            P_SERVE: if (lr) begin nxt = P_PLAY; m_la = 1; end
            P_PLAY: begin
                if (empty) nxt = P_WIN;
                else if (fr) nxt = P_MISS;
            end
            P_MISS: begin
                if (empty) nxt = P_WIN;
                else if (m_lives == 1) begin m_lives = 0; nxt = P_OVER; end
                else begin m_lives--; nxt = P_SERVE; m_br = 1; end
            end
            default: if (sr) begin
                m_map = '1; m_score = 0; m_lives = 3; nxt = P_SERVE; m_br = 1;
            end
        endcase
        if (was_play && nxt == P_PLAY) begin
            m_tick++;
            if (m_tick == TICK) begin m_step = 1; m_tick = 0; end
        end else begin
            m_tick = 0;
        end
        m_phase = nxt; m_ps = s; m_pl = l; m_pf = f;
    endtask

    task automatic cycle_in(bit s, bit l, bit f, bit req, int x, int y);
        start_s = s; launch_s = l; fall_s = f;
        hif.hit_req = req; hif.hit_x = 4'(x); hif.hit_y = 4'(y);
        @(posedge clk);
        model_edge(s, l, f, req, x, y);
        #1;
    endtask

    task automatic clear_all(bit fall_on_last);
        for (int i = 0; i < 20; i++) begin
            cycle_in(0, 0, fall_on_last && (i == 19), 1, i % 10, 8 + i / 10);
            check_model("clear_model");
            check_val("clear_hit_brick", int'(hif.hit_brick), 1);
        end
        check_val("clear_score", int'(score_s), 20);
    endtask

    typedef struct {
        bit s, l, f, req;
        int x, y;
        int st;
        logic [19:0] mp;
        int sc, lv;
        bit stp, br, la, ack, brk;
    } vec_t;

    vec_t tbl[24];

    initial begin
        // s l f r x y | state map score lives step brst launch ack brick
        tbl[0]  = '{0,0,0,0,0,0, 0,20'hFFFFF,0,3, 0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0, 1,20'hFFFFF,0,3, 0,1,0,0,0};
        tbl[2]  = '{1,0,0,0,0,0, 1,20'hFFFFF,0,3, 0,0,0,0,0};
        tbl[3]  = '{0,1,0,0,0,0, 2,20'hFFFFF,0,3, 0,0,1,0,0};
        tbl[4]  = '{0,1,0,0,0,0, 2,20'hFFFFF,0,3, 0,0,0,0,0};
        tbl[5]  = '{0,0,0,1,3,8, 2,20'hFFFF7,1,3, 0,0,0,1,1};
        tbl[6]  = '{0,0,0,1,3,8, 2,20'hFFFF7,1,3, 0,0,0,1,0};
        tbl[7]  = '{0,0,0,1,3,5, 2,20'hFFFF7,1,3, 1,0,0,1,0};
        tbl[8]  = '{0,0,0,0,0,0, 2,20'hFFFF7,1,3, 0,0,0,0,0};
        tbl[9]  = '{0,0,0,0,0,0, 2,20'hFFFF7,1,3, 0,0,0,0,0};
        tbl[10] = '{0,0,0,0,0,0, 2,20'hFFFF7,1,3, 0,0,0,0,0};
        tbl[11] = '{0,0,0,0,0,0, 2,20'hFFFF7,1,3, 1,0,0,0,0};
        tbl[12] = '{0,0,1,0,0,0, 3,20'hFFFF7,1,3, 0,0,0,0,0};
        tbl[13] = '{0,0,1,0,0,0, 1,20'hFFFF7,1,2, 0,1,0,0,0};
        tbl[14] = '{0,0,0,0,0,0, 1,20'hFFFF7,1,2, 0,0,0,0,0};
        tbl[15] = '{0,1,0,0,0,0, 2,20'hFFFF7,1,2, 0,0,1,0,0};
        tbl[16] = '{1,1,1,0,0,0, 3,20'hFFFF7,1,2, 0,0,0,0,0};
        tbl[17] = '{0,0,0,0,0,0, 1,20'hFFFF7,1,1, 0,1,0,0,0};
        tbl[18] = '{0,0,0,0,0,0, 1,20'hFFFF7,1,1, 0,0,0,0,0};
        tbl[19] = '{0,1,0,0,0,0, 2,20'hFFFF7,1,1, 0,0,1,0,0};
        tbl[20] = '{0,1,1,0,0,0, 3,20'hFFFF7,1,1, 0,0,0,0,0};
        tbl[21] = '{0,0,0,0,0,0, 5,20'hFFFF7,1,0, 0,0,0,0,0};
        tbl[22] = '{1,0,0,0,0,0, 1,20'hFFFFF,0,3, 0,1,0,0,0};
        tbl[23] = '{1,0,0,0,0,0, 1,20'hFFFFF,0,3, 0,0,0,0,0};

        hif.hit_req = 1'b0; hif.hit_x = 4'd0; hif.hit_y = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_state", pack(P_IDLE, 20'hFFFFF, 0, 3, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            cycle_in(tbl[i].s, tbl[i].l, tbl[i].f, tbl[i].req, tbl[i].x, tbl[i].y);
            check_vec($sformatf("vec%0d", i), pack(tbl[i].st, tbl[i].mp, tbl[i].sc, tbl[i].lv,
                      tbl[i].stp, tbl[i].br, tbl[i].la, tbl[i].ack, tbl[i].brk));
        end

        // Last brick cleared together with a miss: MISS then WIN, lives kept.
        cycle_in(0, 1, 0, 0, 0, 0);
        check_val("relaunch_state", int'(state_s), P_PLAY);
        clear_all(1'b1);
        check_val("coincident_miss", int'(state_s), P_MISS);
        cycle_in(0, 0, 0, 0, 0, 0);
        check_val("miss_to_win", int'(state_s), P_WIN);
        check_val("win_lives", int'(lives_s), 3);
        check_val("win_flag", int'(win_s), 1);

        // Restart from WIN, then a plain clear: WIN one cycle after the last ack.
        cycle_in(1, 0, 0, 0, 0, 0);
        check_vec("restart_win", pack(P_SERVE, 20'hFFFFF, 0, 3, 0, 1, 0, 0, 0));
        cycle_in(0, 1, 0, 0, 0, 0);
        check_model("launch2");
        clear_all(1'b0);
        check_val("after_last_ack", int'(state_s), P_PLAY);
        cycle_in(0, 0, 0, 0, 0, 0);
        check_val("plain_win", int'(state_s), P_WIN);
        check_val("plain_win_flag", int'(win_s), 1);

        // Reset mid-PLAY with a request pending.
        cycle_in(1, 0, 0, 0, 0, 0);
        cycle_in(0, 1, 0, 0, 0, 0);
        cycle_in(0, 0, 0, 1, 4, 9);
        check_model("pre_reset");
        hif.hit_req = 1'b1; hif.hit_x = 4'd2; hif.hit_y = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset", pack(P_IDLE, 20'hFFFFF, 0, 3, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_vec("reset_drops_req", pack(P_IDLE, 20'hFFFFF, 0, 3, 0, 0, 0, 0, 0));
        hif.hit_req = 1'b0; start_s = 1'b0; launch_s = 1'b0; fall_s = 1'b0;
        model_reset();
        rst_n = 1'b1;

        // Randomized play against the model.
        for (int n = 0; n < 1500; n++) begin
            bit rs, rl, rf, rq;
            int rx, ry;
            rs = ($urandom_range(0, 15) == 0);
            rl = ($urandom_range(0, 3) == 0);
            rf = ($urandom_range(0, 19) == 0);
            rq = ($urandom_range(0, 1) == 1);
            rx = $urandom_range(0, 11);
            ry = ($urandom_range(0, 3) != 0) ? $urandom_range(8, 9) : $urandom_range(0, 15);
            cycle_in(rs, rl, rf, rq, rx, ry);
            check_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the brick-breaker datapath. It sequences the ball engine through serve, launch, play, miss and end-of-game phases, and generates the ball-step tick. It owns the brick map, the score and the lives counter. It sits between the user buttons and the ball-motion block, and arbitrates brick-hit requests from the ball engine against the brick map.

## Interface
- TICK_DIV, 5_000_000, clk cycles per ball step (≥2)
- LIVES, 3, lives at game start (1..7)
- BRICK_ROWS, 2, brick rows at top of 10x10 grid (1..4); BRICK_BASE = 10 − BRICK_ROWS

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  start/restart button, synchronous level, rising edge acts
- launch_btn  in  1  launch button, synchronous level, rising edge acts
- fall_down  in  1  ball-missed-paddle flag from ball engine, rising edge acts
- hit_req  in  1  single-cycle brick probe request
- hit_x  in  4  probed column 0..9
- hit_y  in  4  probed row 0..9
- step  out  1  one-cycle ball-advance pulse
- ball_rst  out  1  one-cycle pulse: re-park ball on paddle
- launch  out  1  one-cycle pulse: release ball
- hit_ack  out  1  one-cycle response to hit_req
- hit_brick  out  1  valid with hit_ack: brick was present, now cleared
- brick_map  out  10*BRICK_ROWS  bit 10r+x = brick at (x, BRICK_BASE+r)
- score  out  8  bricks cleared, saturates at 255
- lives  out  3  remaining lives
- state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, WIN=4, OVER=5
- game_win, game_over  out  1 each  high while in WIN / OVER

## Operation
- Edge detect: start, launch_btn and fall_down are each registered once. The rise signal is the current value AND NOT the registered value.
- IDLE: holds brick_map all ones, score=0, lives=LIVES. On a start rise, go to SERVE and pulse ball_rst.
- SERVE: on a launch_btn rise, go to PLAY and pulse launch.
- PLAY: tick counter runs. Transitions, in priority order:
  - brick_map==0 → WIN
  - fall_down rise → MISS
- MISS: lasts one cycle.
  - If brick_map==0 → WIN; lives unchanged.
  - Else if lives==1 → lives=0, OVER.
  - Else lives−1, SERVE, pulse ball_rst.
- WIN/OVER: hold the state. On a start rise:
  - Reload brick_map all ones, score=0, lives=LIVES.
  - Go to SERVE and pulse ball_rst.
- Tick counter: width clog2(TICK_DIV).
  - Counts 0..TICK_DIV−1 only in PLAY; step pulses when count==TICK_DIV−1, then count wraps to 0.
  - Count is held at 0 in every other state.
- Hit arbitration (all states):
  - hit_req in cycle N → hit_ack=1 in cycle N+1.
  - In range means PLAY, hit_x≤9 and BRICK_BASE≤hit_y≤9. Index = (hit_y−BRICK_BASE)*10 + hit_x.
  - In range: hit_brick = brick_map[index]. If that bit was 1, clear it at the same edge and add 1 to score (saturating).
  - Out of range, or any state other than PLAY: hit_brick=0, no change to the map or score.
- Simultaneous events:
  - hit_req and a fall_down rise in the same cycle: the hit is still acked and applied, and the state goes to MISS. MISS then checks for a fully cleared map.
  - start rise during PLAY/SERVE/MISS is ignored.
  - launch_btn rise outside SERVE is ignored.
- Reset, async at any time:
  - state=IDLE, brick_map all ones, score=0, lives=LIVES, tick count=0, edge registers=0.
  - All pulse outputs, hit_brick, game_win and game_over = 0.
  - A request pending at reset is dropped; no ack.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- A button rise sampled at edge N changes state at edge N+1. ball_rst/launch are high exactly in the cycle after edge N+1 (same cycle the new state is visible).
- Entering PLAY at edge E gives the first step at edge E+TICK_DIV; the step period is then TICK_DIV.
- The hit-to-ack latency is exactly 1 cycle. Back-to-back hit_req are supported, one ack per request.
- brick_map/score update at the ack edge. WIN is entered one cycle after the last brick clears.

## Test plan
- Reset, then start pulse: state 0→1, ball_rst single pulse, lives=3, brick_map=20'hFFFFF (BRICK_ROWS=2).
- TICK_DIV=4: launch_btn in SERVE → launch pulse, PLAY; step pulses every 4 cycles. No step before launch.
- In PLAY, hit (3,8): ack next cycle, hit_brick=1, bit 3 cleared, score=1. Repeat → hit_brick=0, score stays 1. Hit (3,5) → ack, hit_brick=0.
- Three fall_down rises with SERVE/launch between them: lives 3→2→1→0. The third goes MISS→OVER, game_over=1. start → SERVE, lives=3, map full.
- Clear all 20 bricks: WIN after the last ack, game_win=1. Last clear coincident with a fall_down rise → MISS→WIN, lives unchanged.
- Assert rst_n low mid-PLAY with hit_req pending: no ack, all outputs at reset values, state=IDLE.
